uart_rx: RTL
============

Name: uart_rx

Overview:
- Asynchronous serial receiver. It is the receive-side counterpart of the team's 7-bit-with-parity UART transmitter datapath and state machine.
- It oversamples a serial line and recovers frames of the form start(0), DATA_BITS data bits LSB-first, one parity bit, stop(1).
- For each frame it presents the parallel data word, a one-cycle valid strobe, and parity and framing error flags.
- It sits between the pad-side rxd line and the consumer logic.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit. Must be an even number, >= 4.
- DATA_BITS, 7: data bits per frame.

Ports:
- clk  input  1  system clock; rising-edge.
- rst  input  1  reset; asynchronous, active-high.
- rxd  input  1  serial line; idles high; asynchronous to clk.
- p_s  input  1  parity select: 0 = even, 1 = odd. Sampled once per frame at start confirmation.
- dout  output  DATA_BITS  received data word; held until the next completed frame.
- valid  output  1  one-cycle pulse when dout/parity_err/frame_err update.
- parity_err  output  1  received parity bit mismatched; held with dout.
- frame_err  output  1  stop bit sampled low; held with dout.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; counters=0.
  - dout=0, valid=0, parity_err=0, frame_err=0, busy=0.
  - Both synchronizer flops=1.
  - Reset mid-frame abandons the frame with no valid pulse.
- rxd input:
  - Passes through a 2-flop synchronizer before any use; rxs is the synchronizer output.
  - All timing below is relative to rxs.
- Start detection:
  - In IDLE, rxs=0 moves to START on the next edge. The tick counter clears and busy asserts.
- Bit-period counter (tick):
  - Counts 0..CLKS_PER_BIT-1.
  - Bit index counts 0..DATA_BITS-1.
- States:
  - IDLE: wait for rxs=0.
  - START: at tick = CLKS_PER_BIT/2-1 (mid start bit), sample rxs.
    - rxs=1 is a glitch: return to IDLE, no valid, no flag change.
    - rxs=0: latch p_s, clear tick, go to DATA.
  - DATA: at each tick = CLKS_PER_BIT-1 (mid bit), shift rxs into the MSB of the shift register (LSB-first reception). Clear tick and increment bit index. After bit DATA_BITS-1, go to PARITY.
  - PARITY: at mid bit, capture rxs as the received parity bit, then go to STOP.
  - STOP: at mid bit, sample rxs and complete the frame (see below), then return to IDLE on the same edge.
- Frame completion (STOP sample edge):
  - Load dout from the shift register.
  - Expected parity = XOR(data) XOR latched p_s. parity_err = received parity != expected parity.
  - frame_err = !rxs.
  - valid=1 for exactly one cycle.
  - Data is still delivered when an error flag is set.
- Latency: valid rises 2 cycles (synchronizer) plus (DATA_BITS+2) x CLKS_PER_BIT + CLKS_PER_BIT/2 cycles after the rxd falling edge, ±1 cycle.
- Back-to-back frames:
  - The return to IDLE at mid stop bit means a start edge immediately after the stop bit is detected.
  - If frame_err occurs (line still low), the IDLE state re-triggers START. The glitch check rejects it if the line rises before mid-bit.
- p_s changes mid-frame have no effect until the next start confirmation.
- Outputs are registered; no combinational path from rxd or p_s to any output.

Test Plan:
- Setup: CLKS_PER_BIT=16, DATA_BITS=7. The bench drives frames at 16 clk per bit.
- Even parity, valid frame: p_s=0; send data 7'b0000011, parity bit 0, stop 1.
  - Required: valid pulse exactly once; dout=7'h03; parity_err=0; frame_err=0.
  - busy high from start detection until the STOP sample, then low.
- Odd parity mismatch: p_s=1; same frame with parity bit 0.
  - Required: dout=7'h03, parity_err=1, frame_err=0, one valid pulse.
- Framing error: p_s=0; data 7'h55, correct parity 0, stop bit driven 0.
  - Required: dout=7'h55, frame_err=1, parity_err=0.
  - The receiver then rejects the held-low line as a new start only once it returns high before mid-bit; no spurious valid.
- Start glitch: rxd low for 5 clk, then high.
  - Required: busy pulses, returns to IDLE within 8 clk of detection; no valid pulse; dout and flags unchanged.
- Back-to-back frames with no idle gap: 7'h55 then 7'h2A, both with even parity correct.
  - Required: two valid pulses, about 160 clk apart; dout=7'h55 then 7'h2A; no error flags.
- Reset mid-frame: assert rst asynchronously (not clock-aligned) during DATA bit 3.
  - Required: all outputs 0 immediately.
  - After release, a following clean 7'h03 frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling asynchronous serial receiver.
// Frame format: start(0), DATA_BITS data bits LSB-first, parity bit, stop(1).
// rxd is synchronized before use; every output is registered.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 p_s,
    output logic [DATA_BITS-1:0] dout,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned TICK_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_END = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic                   rx_meta_q, rxs_q;
    logic [TICK_W-1:0]      tick_q, tick_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   ps_q, ps_d;
    logic                   par_q, par_d;
    logic [DATA_BITS-1:0]   dout_q, dout_d;
    logic                   valid_q, valid_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   busy_q, busy_d;

    // Two-flop synchronizer on the asynchronous serial line; resets to idle-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rxs_q     <= rx_meta_q;
        end
    end

    // State, counters, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ps_q    <= 1'b0;
            par_q   <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ps_q    <= ps_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: mid-bit sampling of rxs and frame completion.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ps_d    = ps_q;
        par_d   = par_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;

        unique case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d = START;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (tick_q == TICK_MID) begin
                    tick_d = '0;
                    if (rxs_q) begin
                        // Line rose before mid start bit: treat as a glitch.
                        state_d = IDLE;
                    end else begin
                        ps_d    = p_s;
                        state_d = DATA;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            DATA: begin
                if (tick_q == TICK_END) begin
                    tick_d  = '0;
                    shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = PARITY;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            PARITY: begin
                if (tick_q == TICK_END) begin
                    tick_d  = '0;
                    par_d   = rxs_q;
                    state_d = STOP;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            STOP: begin
                if (tick_q == TICK_END) begin
                    // Data is delivered even when an error flag is raised.
                    tick_d  = '0;
                    dout_d  = shift_q;
                    perr_d  = par_q ^ (^shift_q) ^ ps_q;
                    ferr_d  = !rxs_q;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign dout       = dout_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule
